// File: rtl/lcd8080_bus_master.sv
// Intel-8080-style parallel LCD bus master: panel reset sequencing, timed write strobes, CS bursts.
// Define LCD8080_READ_EN to add the bus-read path (req_rd, lcd_data_in, rsp_valid, rsp_data).
//
// state     | meaning
// RST_LOW   | lcd_rst_n held low for RST_LOW_CYC cycles
// RST_WAIT  | panel settling after lcd_rst_n rises; init_done at exit
// IDLE      | req_ready high, waiting for a request; CS held low inside a burst
// SETUP     | RS/CS/data stable before the strobe falls
// STROBE    | lcd_wr_n low for WR_LOW_CYC cycles
// RD_STROBE | lcd_rd_n low for RD_LOW_CYC cycles (read build only)
// HOLD      | strobe high, bus held for WR_HIGH_CYC cycles
module lcd8080_bus_master #(
  parameter int DATA_W       = 16,
  parameter int SETUP_CYC    = 1,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RD_LOW_CYC   = 4,
  parameter int RST_LOW_CYC  = 500,
  parameter int RST_WAIT_CYC = 6000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rs,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_last,
`ifdef LCD8080_READ_EN
  input  logic              req_rd,
  input  logic [DATA_W-1:0] lcd_data_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
`endif
  output logic              init_done,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic              lcd_rst_n,
  output logic [DATA_W-1:0] lcd_data_out,
  output logic              lcd_data_oe
);

  localparam int MAX_A = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
  localparam int MAX_B = (WR_HIGH_CYC > RD_LOW_CYC) ? WR_HIGH_CYC : RD_LOW_CYC;
  localparam int MAX_C = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD
`ifdef LCD8080_READ_EN
    , RD_STROBE
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_q;
  logic             cnt_zero;

  function automatic logic [CNT_W-1:0] load(input int n);
    return CNT_W'(n - 1);
  endfunction

  assign cnt_zero = (cnt == '0);

`ifdef LCD8080_READ_EN
  logic rd_q;
`else
  assign lcd_rd_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset counts as entry into RST_LOW, so the low phase is timed from release.
      state        <= RST_LOW;
      cnt          <= load(RST_LOW_CYC);
      last_q       <= 1'b0;
      req_ready    <= 1'b0;
      init_done    <= 1'b0;
      lcd_cs_n     <= 1'b1;
      lcd_rs       <= 1'b0;
      lcd_wr_n     <= 1'b1;
      lcd_rst_n    <= 1'b0;
      lcd_data_out <= '0;
      lcd_data_oe  <= 1'b0;
`ifdef LCD8080_READ_EN
      rd_q         <= 1'b0;
      lcd_rd_n     <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
`endif
    end else begin
`ifdef LCD8080_READ_EN
      rsp_valid <= 1'b0;
`endif
      case (state)
        RST_LOW: begin
          if (cnt_zero) begin
            lcd_rst_n <= 1'b1;
            cnt       <= load(RST_WAIT_CYC);
            state     <= RST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RST_WAIT: begin
          if (cnt_zero) begin
            init_done <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready    <= 1'b0;
            lcd_cs_n     <= 1'b0;
            lcd_rs       <= req_rs;
            lcd_data_out <= req_data;
            last_q       <= req_last;
`ifdef LCD8080_READ_EN
            rd_q         <= req_rd;
            lcd_data_oe  <= ~req_rd;
`else
            lcd_data_oe  <= 1'b1;
`endif
            cnt          <= load(SETUP_CYC);
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
`ifdef LCD8080_READ_EN
            if (rd_q) begin
              lcd_rd_n <= 1'b0;
              cnt      <= load(RD_LOW_CYC);
              state    <= RD_STROBE;
            end else begin
              lcd_wr_n <= 1'b0;
              cnt      <= load(WR_LOW_CYC);
              state    <= STROBE;
            end
`else
            lcd_wr_n <= 1'b0;
            cnt      <= load(WR_LOW_CYC);
            state    <= STROBE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_zero) begin
            lcd_wr_n <= 1'b1;
            cnt      <= load(WR_HIGH_CYC);
            state    <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef LCD8080_READ_EN
        RD_STROBE: begin
          if (cnt_zero) begin
            lcd_rd_n  <= 1'b1;
            rsp_data  <= lcd_data_in;
            rsp_valid <= 1'b1;
            cnt       <= load(WR_HIGH_CYC);
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        HOLD: begin
          if (cnt_zero) begin
            req_ready <= 1'b1;
            if (last_q) begin
              lcd_cs_n    <= 1'b1;
              lcd_data_oe <= 1'b0;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd8080_bus_master.sv
// Randomised and directed checks of lcd8080_bus_master against a cycle-index model of the bus timing.
module tb_lcd8080_bus_master;
  localparam int DW = 16;
  localparam int S = 1, L = 2, H = 2, RDL = 4;
  localparam int RLOW = 4, RWAIT = 8;
  localparam int T = S + L + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_rs = 1'b0, req_last = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic req_ready, init_done, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_data_oe;
  logic [DW-1:0] lcd_data_out;
`ifdef LCD8080_READ_EN
  logic req_rd = 1'b0;
  logic [DW-1:0] lcd_data_in = '0;
  logic rsp_valid;
  logic [DW-1:0] rsp_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lcd8080_bus_master #(
    .DATA_W(DW), .SETUP_CYC(S), .WR_LOW_CYC(L), .WR_HIGH_CYC(H), .RD_LOW_CYC(RDL),
    .RST_LOW_CYC(RLOW), .RST_WAIT_CYC(RWAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs),
    .req_data(req_data), .req_last(req_last),
`ifdef LCD8080_READ_EN
    .req_rd(req_rd), .lcd_data_in(lcd_data_in), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`endif
    .init_done(init_done), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
    .lcd_rd_n(lcd_rd_n), .lcd_rst_n(lcd_rst_n), .lcd_data_out(lcd_data_out),
    .lcd_data_oe(lcd_data_oe)
  );

  // Bounded wait for req_ready; an expired bound is recorded as a failed vector.
  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) break;
      @(negedge clk);
    end
    if (req_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL wait_ready: req_ready=%b required 1 within 50 cycles", req_ready);
    end
  endtask

  task automatic measure_rst_seq(output int lo, output int hi, output bit bad);
    lo = 0; hi = 0; bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_rst_n !== 1'b0) break;
      lo++;
      if (req_ready !== 1'b0 || init_done !== 1'b0) bad = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      if (init_done === 1'b1) break;
      hi++;
      if (req_ready !== 1'b0 || lcd_rst_n !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lo, hi;
    bit bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data_oe, lcd_rst_n, req_ready, init_done} !== 8'b1110_0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 11100000",
               {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data_oe, lcd_rst_n, req_ready, init_done});
    end
    vectors++;
    if (lcd_data_out !== 16'h0000) begin
      miscompares++; $display("FAIL reset_data: got %h required 0000", lcd_data_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    measure_rst_seq(lo, hi, bad);
    vectors++;
    if (lo != RLOW) begin miscompares++; $display("FAIL rst_low_len: got %0d required %0d", lo, RLOW); end
    vectors++;
    if (hi != RWAIT) begin miscompares++; $display("FAIL rst_wait_len: got %0d required %0d", hi, RWAIT); end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL ready_in_reset: got req_ready/init_done early, required 0"); end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_init: got %b required 1", req_ready); end
  endtask

  task automatic test_single_write();
    int lows = 0;
    logic exp_wr;
    wait_ready();
    req_valid = 1'b1; req_rs = 1'b0; req_data = 16'h00AA; req_last = 1'b1;
    for (int k = 1; k <= T + 1; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp_wr = (k > S && k <= S + L) ? 1'b0 : 1'b1;
      if (lcd_wr_n === 1'b0) lows++;
      vectors++;
      if (k <= T) begin
        if ({req_ready, lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data_oe, lcd_data_out} !== {1'b0, 1'b0, exp_wr, 1'b0, 1'b1, 16'h00AA}) begin
          miscompares++;
          $display("FAIL single_k%0d: got rdy=%b cs=%b wr=%b rs=%b oe=%b d=%h required rdy=0 cs=0 wr=%b rs=0 oe=1 d=00aa",
                   k, req_ready, lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data_oe, lcd_data_out, exp_wr);
        end
      end else if ({req_ready, lcd_cs_n, lcd_wr_n, lcd_data_oe} !== 4'b1110) begin
        miscompares++;
        $display("FAIL single_end: got rdy=%b cs=%b wr=%b oe=%b required 1 1 1 0",
                 req_ready, lcd_cs_n, lcd_wr_n, lcd_data_oe);
      end
    end
    vectors++;
    if (lows != L) begin miscompares++; $display("FAIL single_wr_low: got %0d required %0d", lows, L); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] dat [3] = '{16'h0022, 16'hABCD, 16'h1234};
    logic          rss [3] = '{1'b0, 1'b1, 1'b1};
    logic [DW:0]   seen [$];
    bit cs_break = 1'b0;
    logic prev_wr = 1'b1;
    wait_ready();
    for (int t = 0; t < 3; t++) begin
      req_valid = 1'b1; req_rs = rss[t]; req_data = dat[t]; req_last = (t == 2);
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (k == 1) req_valid = 1'b0;
        if (lcd_wr_n === 1'b0 && prev_wr === 1'b1) seen.push_back({lcd_rs, lcd_data_out});
        prev_wr = lcd_wr_n;
        if (req_ready === 1'b1) break;
        if (lcd_cs_n !== 1'b0) cs_break = 1'b1;
      end
      if (t < 2 && lcd_cs_n !== 1'b0) cs_break = 1'b1;
    end
    vectors++;
    if (seen.size() != 3) begin miscompares++; $display("FAIL burst_pulses: got %0d required 3", seen.size()); end
    for (int t = 0; t < 3 && t < seen.size(); t++) begin
      vectors++;
      if (seen[t] !== {rss[t], dat[t]}) begin
        miscompares++; $display("FAIL burst_xfer%0d: got %h required %h", t, seen[t], {rss[t], dat[t]});
      end
    end
    vectors++;
    if (cs_break) begin miscompares++; $display("FAIL burst_cs: got cs_n high inside burst required low"); end
    vectors++;
    if (lcd_cs_n !== 1'b1 || lcd_data_oe !== 1'b0) begin
      miscompares++; $display("FAIL burst_end: got cs=%b oe=%b required 1 0", lcd_cs_n, lcd_data_oe);
    end
  endtask

  task automatic test_hold_off();
    logic [DW-1:0] d0, d1;
    d0 = DW'($urandom); d1 = ~d0;
    wait_ready();
    req_valid = 1'b1; req_rs = 1'b1; req_data = d0; req_last = 1'b1;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      req_data = d1;
      vectors++;
      if ({req_ready, lcd_data_out} !== {1'b0, d0}) begin
        miscompares++; $display("FAIL holdoff_k%0d: got rdy=%b d=%h required rdy=0 d=%h", k, req_ready, lcd_data_out, d0);
      end
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL holdoff_ready: got %b required 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if ({req_ready, lcd_cs_n, lcd_data_out} !== {1'b0, 1'b0, d1}) begin
      miscompares++; $display("FAIL holdoff_second: got rdy=%b cs=%b d=%h required 0 0 %h", req_ready, lcd_cs_n, lcd_data_out, d1);
    end
    wait_ready();
  endtask

  task automatic test_rst_mid();
    int lo, hi;
    bit bad;
    wait_ready();
    req_valid = 1'b1; req_rs = 1'b1; req_data = 16'hBEEF; req_last = 1'b0;
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    vectors++;
    if (lcd_wr_n !== 1'b0) begin miscompares++; $display("FAIL rstmid_strobe: got wr=%b required 0", lcd_wr_n); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({lcd_wr_n, lcd_cs_n, lcd_data_oe, lcd_rst_n, init_done, req_ready} !== 6'b110000) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got wr=%b cs=%b oe=%b rst_n=%b init=%b rdy=%b required 1 1 0 0 0 0",
               lcd_wr_n, lcd_cs_n, lcd_data_oe, lcd_rst_n, init_done, req_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    measure_rst_seq(lo, hi, bad);
    vectors++;
    if (lo != RLOW || hi != RWAIT || bad) begin
      miscompares++; $display("FAIL rstmid_restart: got lo=%0d hi=%0d bad=%0b required %0d %0d 0", lo, hi, bad, RLOW, RWAIT);
    end
  endtask

  task automatic test_random();
    logic cs_exp = 1'b1;
    logic rs, last, exp_wr;
    logic [DW-1:0] d;
    int gap;
    wait_ready();
    for (int t = 0; t < 24; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        vectors++;
        if ({req_ready, lcd_cs_n} !== {1'b1, cs_exp}) begin
          miscompares++; $display("FAIL rand_idle%0d: got rdy=%b cs=%b required 1 %b", t, req_ready, lcd_cs_n, cs_exp);
        end
      end
      rs = 1'($urandom_range(0, 1)); d = DW'($urandom);
      last = (t == 23) ? 1'b1 : 1'($urandom_range(0, 1));
      req_valid = 1'b1; req_rs = rs; req_data = d; req_last = last;
      for (int k = 1; k <= T + 1; k++) begin
        @(negedge clk);
        if (k == 1) begin req_valid = 1'b0; req_data = DW'($urandom); req_rs = ~rs; end
        exp_wr = (k > S && k <= S + L) ? 1'b0 : 1'b1;
        vectors++;
        if (k <= T) begin
          if ({req_ready, lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data_oe, lcd_data_out} !== {1'b0, 1'b0, exp_wr, rs, 1'b1, d}) begin
            miscompares++;
            $display("FAIL rand%0d_k%0d: got rdy=%b cs=%b wr=%b rs=%b oe=%b d=%h required 0 0 %b %b 1 %h",
                     t, k, req_ready, lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data_oe, lcd_data_out, exp_wr, rs, d);
          end
        end else if ({req_ready, lcd_cs_n, lcd_wr_n, lcd_data_oe} !== {1'b1, last, 1'b1, ~last}) begin
          miscompares++;
          $display("FAIL rand%0d_end: got rdy=%b cs=%b wr=%b oe=%b required 1 %b 1 %b",
                   t, req_ready, lcd_cs_n, lcd_wr_n, lcd_data_oe, last, ~last);
        end
      end
      cs_exp = last;
    end
  endtask

`ifdef LCD8080_READ_EN
  task automatic test_read();
    int lows = 0;
    logic exp_rd;
    wait_ready();
    lcd_data_in = 16'h0000;
    req_valid = 1'b1; req_rd = 1'b1; req_rs = 1'b1; req_data = 16'h1111; req_last = 1'b1;
    for (int k = 1; k <= S + RDL + H + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin req_valid = 1'b0; req_rd = 1'b0; end
      exp_rd = (k > S && k <= S + RDL) ? 1'b0 : 1'b1;
      if (lcd_rd_n === 1'b0) lows++;
      if (k <= S + RDL + H) begin
        vectors++;
        if ({lcd_rd_n, lcd_wr_n, lcd_data_oe, lcd_cs_n, rsp_valid} !== {exp_rd, 1'b1, 1'b0, 1'b0, k == S + RDL + 1}) begin
          miscompares++;
          $display("FAIL read_k%0d: got rd=%b wr=%b oe=%b cs=%b rv=%b required rd=%b wr=1 oe=0 cs=0 rv=%b",
                   k, lcd_rd_n, lcd_wr_n, lcd_data_oe, lcd_cs_n, rsp_valid, exp_rd, k == S + RDL + 1);
        end
      end
      if (k == S + RDL + 1) begin
        vectors++;
        if (rsp_data !== 16'h5A5A) begin miscompares++; $display("FAIL read_data: got %h required 5a5a", rsp_data); end
      end
      lcd_data_in = (k == S + RDL - 1) ? 16'h5A5A : 16'hFFFF;
    end
    vectors++;
    if (lows != RDL) begin miscompares++; $display("FAIL read_rd_low: got %0d required %0d", lows, RDL); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_hold_off();
    test_rst_mid();
    test_random();
`ifdef LCD8080_READ_EN
    test_read();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
